pads_cfg_wb_master: RTL and testbench

// - Wishbone initiator that issues single read/write cycles to the pad-config slave (0x3000_6xxx) and other WB slaves.
// - Local command/response valid-ready interface; one outstanding transaction; ack timeout with bounded retry.
// - Lets the boot/loopback sequencer program OEN for mprj[37:0] without the management core.

---
 rtl/pads_cfg_wb_master.sv | 174 +++++++++++++++++
 tb/tb_pads_cfg_wb_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pads_cfg_wb_master.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pads_cfg_wb_master
//
// Wishbone initiator that issues single read/write cycles on behalf of a
// local command/response handshake. It lets the boot/loopback sequencer
// program the pad-config slave (OEN for mprj[37:0]) without the management
// core. Only one transaction is ever outstanding.
//
// If a slave does not acknowledge within TIMEOUT strobe cycles, the cycle is
// abandoned, the bus idles for one cycle, and the access is re-issued. This
// repeats up to MAX_RETRY times. If every attempt times out, the response
// reports an error.
//
// Ports
//   clk, resetb            clock; asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (accepted only while idle)
//   cmd_we/sel/adr/dat     command fields, latched at acceptance
//   rsp_valid/rsp_ready    response handshake
//   rsp_dat                read data (0 for writes and errors)
//   rsp_err                1 when all attempts timed out
//   rsp_retries            number of timeouts seen before completion
//   busy                   transaction in flight
//   wbm_*                  Wishbone master signals
//
// Parameters
//   TIMEOUT    strobe cycles per attempt before giving up (>= 2)
//   MAX_RETRY  re-issues after a timeout before reporting error (0..3)
// ---------------------------------------------------------------------------
module pads_cfg_wb_master #(
    parameter int TIMEOUT   = 16,
    parameter int MAX_RETRY = 2
) (
    input  logic        clk,
    input  logic        resetb,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic [1:0]  rsp_retries,

    output logic        busy,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    localparam int             TW     = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);
    localparam logic [1:0]     R_MAX  = 2'(MAX_RETRY);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_GAP  = 2'd2,
        S_RSP  = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;   // strobe cycles already spent in this attempt
    logic [1:0]    retry;   // timeouts seen so far in this transaction

    // The bus is word addressed; the byte offset is replaced by zeros.
    logic unused_adr_bits;
    assign unused_adr_bits = ^cmd_adr[1:0];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state       <= S_IDLE;
            timer       <= '0;
            retry       <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            rsp_retries <= '0;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            wbm_we_o    <= 1'b0;
            wbm_sel_o   <= '0;
            wbm_adr_o   <= '0;
            wbm_dat_o   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        // The wbm_* registers double as the command latches.
                        wbm_we_o  <= cmd_we;
                        wbm_sel_o <= cmd_sel;
                        wbm_adr_o <= {cmd_adr[31:2], 2'b00};
                        wbm_dat_o <= cmd_dat;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        timer     <= '0;
                        retry     <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_BUS;
                    end
                end

                S_BUS: begin
                    // Ack is tested first, so an ack arriving on the final
                    // strobe cycle of an attempt still counts as success.
                    if (wbm_ack_i) begin
                        wbm_cyc_o   <= 1'b0;
                        wbm_stb_o   <= 1'b0;
                        rsp_dat     <= wbm_we_o ? 32'd0 : wbm_dat_i;
                        rsp_err     <= 1'b0;
                        rsp_retries <= retry;
                        state       <= S_RSP;
                    end else if (timer == T_LAST) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        timer     <= '0;
                        if (retry < R_MAX) begin
                            retry <= retry + 2'd1;
                            state <= S_GAP;
                        end else begin
                            rsp_dat     <= '0;
                            rsp_err     <= 1'b1;
                            rsp_retries <= retry;
                            state       <= S_RSP;
                        end
                    end else begin
                        // Only reached below T_LAST, so the timer never wraps.
                        timer <= timer + TW'(1);
                    end
                end

                S_GAP: begin
                    // One idle bus cycle separates attempts; a late ack
                    // landing here has no effect.
                    wbm_cyc_o <= 1'b1;
                    wbm_stb_o <= 1'b1;
                    state     <= S_BUS;
                end

                S_RSP: begin
                    // First RSP cycle raises rsp_valid; the response then
                    // holds until it is consumed.
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pads_cfg_wb_master.sv
`timescale 1ns/1ps
module tb_pads_cfg_wb_master;

    localparam int TO = 16;
    localparam int MR = 2;

    logic        clk = 1'b0;
    logic        resetb;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [3:0]  cmd_sel;
    logic [31:0] cmd_adr, cmd_dat;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [1:0]  rsp_retries;
    logic        busy;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic        wbm_ack_i;
    logic [31:0] wbm_dat_i;

    int checks = 0;
    int errors = 0;

    pads_cfg_wb_master #(.TIMEOUT(TO), .MAX_RETRY(MR)) dut (
        .clk(clk), .resetb(resetb),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_sel(cmd_sel), .cmd_adr(cmd_adr), .cmd_dat(cmd_dat),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .rsp_retries(rsp_retries), .busy(busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One command from acceptance to consumed response.
    // p0..p2: stb-cycle index (0-based) at which the slave acks in each
    // attempt, or -1 for a silent attempt.
    task automatic run_txn(input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] wdat,
                           input int p0, input int p1, input int p2,
                           input logic [31:0] rd_val, input int ready_delay,
                           input bit gap_ack);
        int          plan [MR+1];
        int          k, exp_lat, exp_bursts, exp_retries;
        logic        exp_err;
        logic [31:0] exp_dat;
        int          e, att, idx, bursts;
        bit          prev_stb, ack;

        plan[0] = p0; plan[1] = p1; plan[2] = p2;

        // Reference: first attempt that gets an ack decides the outcome.
        // Every timed-out attempt costs TO strobe cycles plus one gap cycle;
        // the successful one costs d+1 cycles, then one more edge to rsp_valid.
        k = -1;
        for (int i = 0; i <= MR; i++)
            if (k < 0 && plan[i] >= 0 && plan[i] < TO) k = i;
        if (k < 0) begin
            exp_err     = 1'b1;
            exp_dat     = 32'd0;
            exp_retries = MR;
            exp_bursts  = MR + 1;
            exp_lat     = (MR + 1) * TO + MR + 1;
        end else begin
            exp_err     = 1'b0;
            exp_dat     = we ? 32'd0 : rd_val;
            exp_retries = k;
            exp_bursts  = k + 1;
            exp_lat     = k * (TO + 1) + plan[k] + 2;
        end

        chk("idle_ready", {30'd0, busy, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = wdat;
        wbm_ack_i = 1'b0;
        step();
        chk("stb_after_accept", {31'd0, wbm_stb_o}, 32'd1);

        e = 0; att = -1; idx = 0; bursts = 0; prev_stb = 1'b0;
        while (!rsp_valid) begin
            if (e > exp_lat + 4) begin
                chk("rsp_wait", e, exp_lat);
                cmd_valid = 1'b0;
                return;
            end
            chk("inflight", {30'd0, busy, cmd_ready}, 32'd2);
            if (wbm_stb_o) begin
                if (!prev_stb) begin att++; idx = 0; bursts++; end
                else idx++;
                chk("wb_cyc", {31'd0, wbm_cyc_o}, 32'd1);
                chk("wb_adr", wbm_adr_o, {adr[31:2], 2'b00});
                chk("wb_ctl", {27'd0, wbm_we_o, wbm_sel_o}, {27'd0, we, sel});
                chk("wb_dat", wbm_dat_o, wdat);
                ack = (att >= 0 && att <= MR && plan[att] == idx);
                wbm_ack_i = ack;
                wbm_dat_i = ack ? rd_val : $urandom;
            end else begin
                chk("wb_cyc_low", {31'd0, wbm_cyc_o}, 32'd0);
                wbm_ack_i = gap_ack ? 1'b1 : ($urandom_range(0, 3) == 0);
                wbm_dat_i = $urandom;
            end
            prev_stb  = wbm_stb_o;
            // Junk commands while busy must never be captured.
            cmd_valid = $urandom_range(0, 1);
            cmd_we    = $urandom_range(0, 1);
            cmd_sel   = 4'($urandom);
            cmd_adr   = $urandom;
            cmd_dat   = $urandom;
            rsp_ready = $urandom_range(0, 1);
            step();
            e++;
        end

        chk("latency", e, exp_lat);
        chk("bursts", bursts, exp_bursts);
        chk("rsp_dat", rsp_dat, exp_dat);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        chk("rsp_retries", {30'd0, rsp_retries}, exp_retries);

        for (int i = 0; i < ready_delay; i++) begin
            rsp_ready = 1'b0;
            cmd_valid = $urandom_range(0, 1);
            wbm_ack_i = $urandom_range(0, 1);
            step();
            chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
            chk("hold_dat", rsp_dat, exp_dat);
            chk("hold_meta", {29'd0, rsp_err, rsp_retries}, {29'd0, exp_err, 2'(exp_retries)});
            chk("hold_ready", {31'd0, cmd_ready}, 32'd0);
        end

        // Consume the response with a command offered in the same cycle:
        // it must not be taken.
        rsp_ready = 1'b1;
        cmd_valid = 1'b1;
        step();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        wbm_ack_i = 1'b0;
        chk("rsp_drop", {31'd0, rsp_valid}, 32'd0);
        chk("back_idle", {30'd0, busy, cmd_ready}, 32'd1);
        chk("exit_no_stb", {31'd0, wbm_stb_o}, 32'd0);
    endtask

    initial begin
        int p [3];
        resetb    = 1'b0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_sel = '0; cmd_adr = '0; cmd_dat = '0;
        rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
        repeat (3) @(negedge clk);

        chk("rst_ready", {30'd0, busy, cmd_ready}, 32'd1);
        chk("rst_rsp", {28'd0, rsp_valid, rsp_err, rsp_retries}, 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'd0);
        chk("rst_wb", {26'd0, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o[2:0]}, 32'd0);
        chk("rst_wb_adr", wbm_adr_o, 32'd0);
        resetb = 1'b1;
        step();

        // Write, ack one cycle after stb.
        run_txn(1'b1, 4'hF, 32'h3000_6000, 32'h0000_0FF0, 1, -1, -1, $urandom, 0, 1'b0);
        // Read, zero-wait ack.
        run_txn(1'b0, 4'hF, 32'h3000_6004, $urandom, 0, -1, -1, 32'hA5A5_5A5A, 0, 1'b0);
        // Silent slave: all attempts time out.
        run_txn(1'b0, 4'hF, 32'h3000_6008, $urandom, -1, -1, -1, $urandom, 1, 1'b0);
        // Ack on the last cycle of the second attempt; acks forced during gap.
        run_txn(1'b0, 4'h3, 32'h3000_600F, $urandom, -1, TO - 1, -1, 32'h1234_5678, 0, 1'b1);
        // Response back-pressure for 10 cycles.
        run_txn(1'b1, 4'h5, 32'h3000_6010, 32'hDEAD_BEEF, 3, -1, -1, $urandom, 10, 1'b0);

        // Asynchronous reset in the middle of a bus cycle.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_sel = 4'hF; cmd_adr = 32'h3000_6020;
        wbm_ack_i = 1'b0;
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        chk("pre_rst_stb", {31'd0, wbm_stb_o}, 32'd1);
        #2 resetb = 1'b0;
        #1;
        chk("arst_wb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        chk("arst_ctl", {29'd0, rsp_valid, busy, cmd_ready}, 32'd1);
        @(negedge clk);
        resetb = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("post_rst", {29'd0, rsp_valid, wbm_stb_o, cmd_ready}, 32'd1);
        end

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            for (int a = 0; a < 3; a++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 3)       p[a] = -1;
                else if (r == 3) p[a] = TO - 1;
                else             p[a] = $urandom_range(0, TO - 1);
            end
            run_txn($urandom_range(0, 1), 4'($urandom), $urandom, $urandom,
                    p[0], p[1], p[2], $urandom, $urandom_range(0, 3),
                    1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
